// File: rtl/pacman_motion.sv
// pacman_motion: tile-aligned PAC-MAN movement engine feeding the pixel renderer.
// Optional tunnel wrap at the left/right screen edges: define PACMAN_TUNNEL_WRAP_EN.
module pacman_motion #(
    parameter int TILE_SIZE = 20,
    parameter int COLS      = 32,
    parameter int ROWS      = 24,
    parameter int START_COL = 16,
    parameter int START_ROW = 17
) (
    input  logic                                clk_50MHz,
    input  logic                                reset,
    input  logic                                move_tick,
    input  logic                                w,
    input  logic                                a,
    input  logic                                s,
    input  logic                                d,
    input  logic [COLS*ROWS-1:0]                tilemap,
    output logic [$clog2(COLS*TILE_SIZE)-1:0]   char_x,
    output logic [$clog2(ROWS*TILE_SIZE)-1:0]   char_y,
    output logic [1:0]                          dir,
    output logic                                moving,
    output logic [$clog2(COLS)-1:0]             tile_col,
    output logic [$clog2(ROWS)-1:0]             tile_row
);
    localparam int XW   = $clog2(COLS*TILE_SIZE);
    localparam int YW   = $clog2(ROWS*TILE_SIZE);
    localparam int CW   = $clog2(COLS);
    localparam int RW   = $clog2(ROWS);
    localparam int MW   = $clog2(COLS*ROWS);
    localparam int HALF = TILE_SIZE/2;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic {ALIGNED, MOVING} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [1:0]      dir_q, dir_d;
    logic            moving_q, moving_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [1:0]      req_dir_q, req_dir_d;
    logic            req_valid_q, req_valid_d;

    logic            any_key;
    logic [1:0]      key_dir;
    logic [1:0]      step_dir;
    logic            do_step;
    int              cur_col, cur_row, nx, ny;

    // Wall lookup for the tile adjacent to (c, r) in heading hd; off-map rows are walls.
    function automatic logic tile_open(input logic [1:0] hd, input int c, input int r);
        int nc;
        int nr;
        nc = c;
        nr = r;
        case (hd)
            DIR_UP:   nr = r - 1;
            DIR_LEFT: nc = c - 1;
            DIR_DOWN: nr = r + 1;
            default:  nc = c + 1;
        endcase
        if (nr < 0 || nr >= ROWS) return 1'b0;
`ifdef PACMAN_TUNNEL_WRAP_EN
        if (nc < 0) nc = COLS - 1;
        else if (nc >= COLS) nc = 0;
`else
        if (nc < 0 || nc >= COLS) return 1'b0;
`endif
        return ~tilemap[MW'(nr*COLS + nc)];
    endfunction

`ifdef PACMAN_TUNNEL_WRAP_EN
    function automatic logic at_edge(input logic [1:0] hd, input int c);
        return (hd == DIR_LEFT && c == 0) || (hd == DIR_RIGHT && c == COLS - 1);
    endfunction
`endif

    always_comb begin
        any_key     = w | a | s | d;
        key_dir     = w ? DIR_UP : (a ? DIR_LEFT : (s ? DIR_DOWN : DIR_RIGHT));
        req_dir_d   = any_key ? key_dir : req_dir_q;
        req_valid_d = req_valid_q | any_key;
    end

    // A blocked player with both ways shut still turns to face the request.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        dir_d    = dir_q;
        moving_d = moving_q;
        col_d    = col_q;
        row_d    = row_q;
        step_dir = dir_q;
        do_step  = 1'b0;
        cur_col  = int'(col_q);
        cur_row  = int'(row_q);
        nx       = int'(x_q);
        ny       = int'(y_q);
        if (move_tick) begin
            case (state_q)
                ALIGNED: begin
                    if (req_valid_d && tile_open(req_dir_d, cur_col, cur_row)) begin
                        dir_d    = req_dir_d;
                        step_dir = req_dir_d;
                        do_step  = 1'b1;
                    end else if (tile_open(dir_q, cur_col, cur_row)) begin
                        do_step  = 1'b1;
                    end else begin
                        moving_d = 1'b0;
                        if (req_valid_d) dir_d = req_dir_d;
                    end
                end
                MOVING: begin
                    if (req_valid_d && req_dir_d == (dir_q ^ 2'd2)) begin
                        dir_d    = req_dir_d;
                        step_dir = req_dir_d;
                    end
                    do_step = 1'b1;
                end
            endcase
        end
        if (do_step) begin
            moving_d = 1'b1;
            case (step_dir)
                DIR_UP:   ny = ny - 1;
                DIR_LEFT: nx = nx - 1;
                DIR_DOWN: ny = ny + 1;
                default:  nx = nx + 1;
            endcase
            if (state_q == ALIGNED) begin
`ifdef PACMAN_TUNNEL_WRAP_EN
                if (at_edge(step_dir, cur_col)) begin
                    nx    = (step_dir == DIR_LEFT) ? (COLS-1)*TILE_SIZE + HALF : HALF;
                    col_d = (step_dir == DIR_LEFT) ? CW'(COLS-1) : '0;
                end else begin
                    state_d = MOVING;
                end
`else
                state_d = MOVING;
`endif
            end else if (((nx - HALF) % TILE_SIZE) == 0 && ((ny - HALF) % TILE_SIZE) == 0) begin
                col_d   = CW'((nx - HALF) / TILE_SIZE);
                row_d   = RW'((ny - HALF) / TILE_SIZE);
                state_d = ALIGNED;
            end
            x_d = XW'(nx);
            y_d = YW'(ny);
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (!reset) begin
            state_q     <= ALIGNED;
            x_q         <= XW'(START_COL*TILE_SIZE + HALF);
            y_q         <= YW'(START_ROW*TILE_SIZE + HALF);
            dir_q       <= DIR_LEFT;
            moving_q    <= 1'b0;
            col_q       <= CW'(START_COL);
            row_q       <= RW'(START_ROW);
            req_dir_q   <= DIR_UP;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dir_q       <= dir_d;
            moving_q    <= moving_d;
            col_q       <= col_d;
            row_q       <= row_d;
            req_dir_q   <= req_dir_d;
            req_valid_q <= req_valid_d;
        end
    end

    assign char_x   = x_q;
    assign char_y   = y_q;
    assign dir      = dir_q;
    assign moving   = moving_q;
    assign tile_col = col_q;
    assign tile_row = row_q;
endmodule

// File: tb/tb_pacman_motion.sv
// tb_pacman_motion: directed checks of pacman_motion with hand-computed positions.
// A second instance starts at column 0 to exercise the edge (PACMAN_TUNNEL_WRAP_EN aware).
module tb_pacman_motion;
    logic         clk_50MHz = 1'b0;
    logic         reset;
    logic         move_tick;
    logic         move_tick2;
    logic         w, a, s, d;
    logic [767:0] tilemap;
    logic [9:0]   char_x, char_x2;
    logic [8:0]   char_y, char_y2;
    logic [1:0]   dir, dir2;
    logic         moving, moving2;
    logic [4:0]   tile_col, tile_col2, tile_row, tile_row2;
    int           total = 0;
    int           bad = 0;

    always #5 clk_50MHz = ~clk_50MHz;

    pacman_motion dut (
        .clk_50MHz(clk_50MHz), .reset(reset), .move_tick(move_tick),
        .w(w), .a(a), .s(s), .d(d), .tilemap(tilemap),
        .char_x(char_x), .char_y(char_y), .dir(dir), .moving(moving),
        .tile_col(tile_col), .tile_row(tile_row)
    );

    pacman_motion #(.START_COL(0)) dut_edge (
        .clk_50MHz(clk_50MHz), .reset(reset), .move_tick(move_tick2),
        .w(w), .a(a), .s(s), .d(d), .tilemap(tilemap),
        .char_x(char_x2), .char_y(char_y2), .dir(dir2), .moving(moving2),
        .tile_col(tile_col2), .tile_row(tile_row2)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One tick strobe per instance; outputs are sampled on the following falling edge.
    task automatic applyStimulus(input logic t1, input logic t2);
        @(negedge clk_50MHz);
        move_tick  = t1;
        move_tick2 = t2;
        @(negedge clk_50MHz);
        move_tick  = 1'b0;
        move_tick2 = 1'b0;
    endtask

    task automatic pulseKeys(input logic [3:0] wasd);
        @(negedge clk_50MHz);
        {w, a, s, d} = wasd;
        @(negedge clk_50MHz);
        {w, a, s, d} = 4'b0000;
    endtask

    task automatic resetDut();
        @(negedge clk_50MHz);
        {w, a, s, d} = 4'b0000;
        move_tick    = 1'b0;
        move_tick2   = 1'b0;
        tilemap      = '1;
        reset        = 1'b0;
        @(negedge clk_50MHz);
        reset = 1'b1;
    endtask

    task automatic setTile(input int c, input int r, input logic wall);
        tilemap[10'(r*32 + c)] = wall;
    endtask

    task automatic openRow17();
        for (int c = 0; c < 32; c++) setTile(c, 17, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        move_tick = 1'b0;
        move_tick2 = 1'b0;
        {w, a, s, d} = 4'b0000;
        tilemap = '1;
        repeat (2) @(negedge clk_50MHz);
        reset = 1'b1;

        checkOutput("rst x", int'(char_x), 330);
        checkOutput("rst y", int'(char_y), 350);
        checkOutput("rst dir", int'(dir), 1);
        checkOutput("rst moving", int'(moving), 0);
        checkOutput("rst col", int'(tile_col), 16);
        checkOutput("rst row", int'(tile_row), 17);

        // Keys alone never move the player.
        @(negedge clk_50MHz);
        s = 1'b1;
        repeat (3) @(negedge clk_50MHz);
        s = 1'b0;
        checkOutput("hold x", int'(char_x), 330);
        checkOutput("hold y", int'(char_y), 350);
        checkOutput("hold dir", int'(dir), 1);

        resetDut();
        openRow17();
        pulseKeys(4'b0001);
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("run x%0d", i), int'(char_x), 330 + i);
        end
        checkOutput("run col", int'(tile_col), 17);
        checkOutput("run dir", int'(dir), 3);
        checkOutput("run moving", int'(moving), 1);

        resetDut();
        setTile(16, 17, 1'b0);
        @(negedge clk_50MHz);
        d = 1'b1;
        applyStimulus(1'b1, 1'b0);
        d = 1'b0;
        checkOutput("boxed x", int'(char_x), 330);
        checkOutput("boxed moving", int'(moving), 0);
        checkOutput("boxed dir", int'(dir), 3);

        resetDut();
        openRow17();
        setTile(17, 16, 1'b0);
        pulseKeys(4'b0001);
        repeat (5) applyStimulus(1'b1, 1'b0);
        checkOutput("turn x335", int'(char_x), 335);
        pulseKeys(4'b1000);
        repeat (15) applyStimulus(1'b1, 1'b0);
        checkOutput("turn x350", int'(char_x), 350);
        checkOutput("turn dir before", int'(dir), 3);
        applyStimulus(1'b1, 1'b0);
        checkOutput("turn x", int'(char_x), 350);
        checkOutput("turn y", int'(char_y), 349);
        checkOutput("turn dir", int'(dir), 0);

        resetDut();
        openRow17();
        pulseKeys(4'b0001);
        repeat (5) applyStimulus(1'b1, 1'b0);
        pulseKeys(4'b0100);
        applyStimulus(1'b1, 1'b0);
        checkOutput("rev x", int'(char_x), 334);
        checkOutput("rev dir", int'(dir), 1);
        repeat (4) applyStimulus(1'b1, 1'b0);
        checkOutput("rev back x", int'(char_x), 330);
        checkOutput("rev back col", int'(tile_col), 16);

        resetDut();
        openRow17();
        checkOutput("edge start x", int'(char_x2), 10);
        applyStimulus(1'b0, 1'b1);
`ifdef PACMAN_TUNNEL_WRAP_EN
        checkOutput("edge x", int'(char_x2), 630);
        checkOutput("edge col", int'(tile_col2), 31);
        checkOutput("edge moving", int'(moving2), 1);
`else
        checkOutput("edge x", int'(char_x2), 10);
        checkOutput("edge col", int'(tile_col2), 0);
        checkOutput("edge moving", int'(moving2), 0);
`endif
        checkOutput("edge dir", int'(dir2), 1);
        checkOutput("edge idle x", int'(char_x), 330);

        resetDut();
        openRow17();
        pulseKeys(4'b0001);
        repeat (10) applyStimulus(1'b1, 1'b0);
        checkOutput("midrst x340", int'(char_x), 340);
        @(negedge clk_50MHz);
        reset = 1'b0;
        move_tick = 1'b1;
        @(negedge clk_50MHz);
        reset = 1'b1;
        move_tick = 1'b0;
        checkOutput("midrst x", int'(char_x), 330);
        checkOutput("midrst dir", int'(dir), 1);
        checkOutput("midrst moving", int'(moving), 0);
        checkOutput("midrst col", int'(tile_col), 16);
        applyStimulus(1'b1, 1'b0);
        checkOutput("midrst req cleared x", int'(char_x), 329);
        checkOutput("midrst req cleared dir", int'(dir), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
